// File: rtl/led_segment.sv
// Eight-digit hex display scanner driving a pair of cascaded 74HC595 shift
// registers: one 16-bit frame {segments, digit select} per digit slot.
module led_segment #(
  parameter int DIGIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] seg_data_1,
  input  logic [3:0] seg_data_2,
  input  logic [3:0] seg_data_3,
  input  logic [3:0] seg_data_4,
  input  logic [3:0] seg_data_5,
  input  logic [3:0] seg_data_6,
  input  logic [3:0] seg_data_7,
  input  logic [3:0] seg_data_8,
  input  logic [7:0] seg_data_en,
  input  logic [7:0] seg_dot_en,
  output logic       rclk_out,
  output logic       sclk_out,
  output logic       sdio_out
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(64);
  localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(66);

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_LATCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Active-low segment pattern, dp (bit7) off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 8'hC0;
      4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;
      4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;
      4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;
      4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;
      4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;
      4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  logic             run_q, run_d;
  logic [15:0]      frame_q, frame_d;
  logic             rclk_q, rclk_d;
  logic             sclk_q, sclk_d;
  logic             sdio_q, sdio_d;

  logic             frame_start;
  logic [3:0]       dig_val;
  logic [7:0]       seg_code;

  always_comb begin
    // run_q is low only in the first cycle after reset, which opens a frame
    // without advancing the digit index.
    frame_start = !run_q || (cnt_q == CNT_LAST);
    run_d       = 1'b1;
    cnt_d       = frame_start ? '0 : cnt_q + CNT_W'(1);
    dig_d       = (frame_start && run_q) ? dig_q + 3'd1 : dig_q;

    case (dig_d)
      3'd0:    dig_val = seg_data_1;
      3'd1:    dig_val = seg_data_2;
      3'd2:    dig_val = seg_data_3;
      3'd3:    dig_val = seg_data_4;
      3'd4:    dig_val = seg_data_5;
      3'd5:    dig_val = seg_data_6;
      3'd6:    dig_val = seg_data_7;
      default: dig_val = seg_data_8;
    endcase

    seg_code = 8'hFF;
    if (seg_data_en[dig_d]) begin
      seg_code = hex_to_seg(dig_val) & {~seg_dot_en[dig_d], 7'h7F};
    end
    frame_d = frame_start ? {seg_code, ~(8'd1 << dig_d)} : frame_q;

    state_d = state_q;
    if (frame_start) begin
      state_d = ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: if (cnt_d == SHIFT_END) state_d = ST_LATCH;
        ST_LATCH: if (cnt_d == LATCH_END) state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_WAIT;
        default:  state_d = ST_SHIFT;
      endcase
    end

    // Outputs are computed for the upcoming cycle so they land in registers.
    sdio_d = sdio_q;
    sclk_d = 1'b0;
    rclk_d = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        sdio_d = frame_d[4'd15 - cnt_d[5:2]];
        sclk_d = cnt_d[1];
      end
      ST_LATCH: rclk_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SHIFT;
      cnt_q   <= '0;
      dig_q   <= '0;
      run_q   <= 1'b0;
      rclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      run_q   <= run_d;
      rclk_q  <= rclk_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign rclk_out = rclk_q;
  assign sclk_out = sclk_q;
  assign sdio_out = sdio_q;

endmodule

// File: tb/tb_led_segment.sv
// Bench for led_segment: frame-position model checked every cycle, plus a
// serial decoder that reassembles each latched 16-bit word.
module tb_led_segment;
  localparam int DC = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d [8];
  logic [7:0] en, dot;
  logic       rclk, sclk, sdio;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  led_segment #(.DIGIT_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_data_1(d[0]), .seg_data_2(d[1]), .seg_data_3(d[2]), .seg_data_4(d[3]),
    .seg_data_5(d[4]), .seg_data_6(d[5]), .seg_data_7(d[6]), .seg_data_8(d[7]),
    .seg_data_en(en), .seg_dot_en(dot),
    .rclk_out(rclk), .sclk_out(sclk), .sdio_out(sdio)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_code(int k);
    if (!en[k]) return 8'hFF;
    return seg_tab[d[k]] & (dot[k] ? 8'h7F : 8'hFF);
  endfunction

  // Model: position within the frame (-1 = in reset), digit, captured word.
  int          mpos = -1;
  int          mdig = 0;
  logic [15:0] mword = '0;
  int          cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mpos = -1;
      mdig = 0;
    end else if (mpos < 0 || mpos == DC - 1) begin
      mdig  = (mpos < 0) ? 0 : (mdig + 1) % 8;
      mpos  = 0;
      mword = {exp_code(mdig), ~(8'd1 << mdig)};
    end else begin
      mpos++;
    end
  end

  logic [15:0] words [$];
  logic [15:0] sh = '0;
  int          nsc = 0;
  int          prev_rise = 0;
  bit          have_prev = 0;
  logic        psclk = 1'b0, prclk = 1'b0;

  initial forever begin
    logic es, ec, er;
    @(negedge clk);
    if (mpos < 0) begin
      es = 0; ec = 0; er = 0;
    end else if (mpos < 64) begin
      es = mword[15 - mpos / 4]; ec = (mpos % 4) >= 2; er = 0;
    end else begin
      es = mword[0]; ec = 0; er = (mpos == 64 || mpos == 65);
    end
    checks++;
    if ({rclk, sclk, sdio} !== {er, ec, es}) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t pos=%0d {rclk,sclk,sdio} got %b%b%b want %b%b%b",
               $time, mpos, rclk, sclk, sdio, er, ec, es);
    end
    if (mpos < 0) begin
      nsc = 0;
      have_prev = 0;
    end else begin
      if (sclk === 1'b1 && psclk === 1'b0) begin
        sh = {sh[14:0], sdio};
        nsc++;
      end
      if (rclk === 1'b1 && prclk === 1'b0) begin
        checks++;
        if (nsc != 16) begin
          errors++;
          $display("FAIL sclk_per_frame got %0d want 16", nsc);
        end
        if (have_prev) begin
          checks++;
          if (cyc - prev_rise != DC) begin
            errors++;
            $display("FAIL rclk_spacing got %0d want %0d", cyc - prev_rise, DC);
          end
        end
        words.push_back(sh);
        prev_rise = cyc;
        have_prev = 1;
        nsc = 0;
      end
    end
    psclk = sclk;
    prclk = rclk;
  end

  task automatic chk_word(string nm, int i, logic [15:0] exp);
    checks++;
    if (i >= words.size()) begin
      errors++;
      $display("FAIL %s got no frame (only %0d) want %h", nm, words.size(), exp);
    end else if (words[i] !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, words[i], exp);
    end
  endtask

  initial begin
    int k;
    d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h0};
    en = 8'hFD;
    dot = 8'h00;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({rclk, sclk, sdio} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000", {rclk, sclk, sdio});
    end

    words.delete();
    rst_n = 1'b1;
    repeat (9 * DC) @(negedge clk);
    chk_word("slot1", 0, 16'hF9FE);
    chk_word("slot2_blank", 1, 16'hFFFD);
    chk_word("slot3", 2, 16'hB0FB);
    chk_word("slot8", 7, 16'hC07F);
    chk_word("slot9_wrap", 8, 16'hF9FE);

    rst_n = 1'b0;
    dot = 8'h08;
    repeat (3) @(negedge clk);
    words.delete();
    rst_n = 1'b1;
    repeat (4 * DC) @(negedge clk);
    chk_word("digit4_dot", 3, 16'h19F7);

    for (k = 0; k < 10 * DC && !(mdig == 2 && mpos == 20); k++) @(negedge clk);
    checks++;
    if (!(mdig == 2 && mpos == 20)) begin
      errors++;
      $display("FAIL wait_digit3 got pos %0d dig %0d want pos 20 dig 2", mpos, mdig);
    end
    words.delete();
    d[2] = 4'hA;
    repeat (9 * DC) @(negedge clk);
    chk_word("digit3_unchanged", 0, 16'hB0FB);
    chk_word("digit3_updated", 8, 16'h88FB);

    for (k = 0; k < 2 * DC && mpos != 34; k++) @(negedge clk);
    checks++;
    if (mpos != 34) begin
      errors++;
      $display("FAIL wait_bit8 got pos %0d want 34", mpos);
    end
    words.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DC) @(negedge clk);
    checks++;
    if (words.size() != 2) begin
      errors++;
      $display("FAIL abort_frame_count got %0d want 2", words.size());
    end
    chk_word("restart_digit1", 0, 16'hF9FE);

    for (int c = 0; c < 40 * DC; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) d[$urandom_range(0, 7)] = 4'($urandom);
      if ($urandom_range(0, 49) == 0) en = 8'($urandom);
      if ($urandom_range(0, 49) == 0) dot = 8'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1;
    repeat (2 * DC) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_segment.md
LED_SEGMENT -- requirements
Module: led_segment

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000: clk cycles allotted to each digit's scan slot (1 ms at 50 MHz); minimum 80.
REQ-002 clk  input  1  system clock (50 MHz nominal); all logic is on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 seg_data_1 .. seg_data_8  input  4 each  hex value (0-F) for digits 1..8.
REQ-005 seg_data_en  input  8  per-digit enable; bit0 = digit1, bit7 = digit8.
REQ-006 seg_dot_en  input  8  per-digit decimal-point enable, same bit order.
REQ-007 rclk_out  output  1  74HC595 RCK (storage latch).
REQ-008 sclk_out  output  1  74HC595 SCK (shift clock).
REQ-009 sdio_out  output  1  74HC595 SER (serial data).

Function
REQ-010 Digits are time-multiplexed in the order 1,2,...,8, then wrap to 1; one frame is sent per digit slot.
REQ-011 Frame = 16-bit word {seg_code[7:0], dig_sel[7:0]}, shifted MSB first (seg_code bit7 first, dig_sel bit0 last).
REQ-012 dig_sel is one-hot active-low: digit n drives bit n-1 = 0 and all other bits = 1 (digit1 = 8'hFE, digit8 = 8'h7F).
REQ-013 seg_code is active-low: bit7 = dp, bit6..bit0 = g,f,e,d,c,b,a.
REQ-014 Hex decode for seg_code[6:0] with bit7 = 1: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-015 When the digit's seg_data_en bit is 1 and its seg_dot_en bit is 1, seg_code bit7 is 0.
REQ-016 When the digit's seg_data_en bit is 0, seg_code = 8'hFF (blank, dp off) regardless of value or dot; the slot is still consumed.
REQ-017 The digit value, enable and dot bits are captured in the first cycle of each frame; input changes during a frame affect only later frames.
REQ-018 State machine: SHIFT -> LATCH -> WAIT -> SHIFT.
REQ-019 SHIFT: each bit lasts 4 clk cycles. sdio_out is updated at the start of the bit period; sclk_out is 0 for cycles 0-1 and 1 for cycles 2-3. This repeats for 16 bits (64 cycles).
REQ-020 LATCH: rclk_out = 1 for 2 cycles with sclk_out = 0; exactly one rclk pulse per frame.
REQ-021 WAIT: sclk_out = 0 and rclk_out = 0; sdio_out holds its last value.
REQ-022 A slot counter counts 0..DIGIT_CYCLES-1 from the frame start. When it wraps, the digit index advances (8 -> 1) and SHIFT begins the next frame.
REQ-023 The frame period is exactly DIGIT_CYCLES clk cycles.
REQ-024 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n = 0 at a clk edge: rclk_out = 0, sclk_out = 0, sdio_out = 0, digit index = 1, slot counter = 0, state = SHIFT (pending).
REQ-026 First frame (digit1) starts in the first cycle after rst_n is sampled high; its first sdio_out bit is valid in that cycle.
REQ-027 Reset asserted mid-frame aborts the frame immediately, with no rclk pulse; after release, transmission restarts at digit1, bit 15.

Verification
REQ-028 Reset then release with data 1,2,3,4,5,7,8,0, en = 8'hFD, dot = 8'h00 -> outputs 0 during reset; the digit1 frame shifted on sclk rising edges = 16'hF9FE, then one rclk pulse.
REQ-029 Same stimulus, second slot -> digit2 disabled, frame = 16'hFFFD; third slot frame = 16'hB0FB; eighth slot frame = 16'hC07F; ninth slot is digit1 again (16'hF9FE).
REQ-030 Dot on digit4 enabled (dot = 8'h08, en bit3 = 1, value 4) -> digit4 frame = 16'h19F7.
REQ-031 Timing check -> 16 sclk rising edges and 1 rclk pulse per frame; rclk rising edge at cycle 64 of the frame; successive rclk rising edges DIGIT_CYCLES apart.
REQ-032 Value changed to 4'hA during the digit3 frame -> current frame unchanged; the next digit3 frame carries 8'h88.
REQ-033 rst_n pulsed low during bit 8 of a frame -> no rclk pulse for that frame; the following frame is digit1 with correct timing.
